// File: rtl/pool_stream.sv
// Streaming K x K / stride-K pooling (max or floor-average) over raster-ordered pixels,
// keeping one row of partial window results instead of a frame buffer.
module pool_stream #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int LK = (K == 4) ? 2 : 1;
  localparam int SH = 2 * LK;
  localparam int AW = WIDTH + SH;
  localparam int NW = IMG_W / K;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   mode_q, mode_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic signed [AW-1:0]   pbuf_q [NW];

  logic                   accept, first_px, mode_eff, h_done, win_done, row_end, frame_end;
  logic [LK-1:0]          kx, ky;
  logic [WW-1:0]          wc;
  logic signed [AW-1:0]   pix, pb, h, v;

  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    accept    = in_valid && in_ready;
    first_px  = (col_q == '0) && (row_q == '0);
    // The frame's first pixel must already use the mode being latched with it.
    mode_eff  = first_px ? mode : mode_q;
    kx        = col_q[LK-1:0];
    ky        = row_q[LK-1:0];
    wc        = WW'(col_q >> LK);
    pix       = {{SH{in_data[WIDTH-1]}}, in_data};
    pb        = pbuf_q[wc];
    h_done    = (kx == LK'(K-1));
    win_done  = accept && h_done && (ky == LK'(K-1));
    row_end   = (col_q == CW'(IMG_W-1));
    frame_end = row_end && (row_q == RW'(IMG_H-1));

    if (kx == '0)    h = pix;
    else if (mode_eff) h = acc_q + pix;
    else             h = (pix > acc_q) ? pix : acc_q;

    if (ky == '0)    v = h;
    else if (mode_eff) v = pb + h;
    else             v = (h > pb) ? h : pb;

    col_d  = col_q;
    row_d  = row_q;
    acc_d  = acc_q;
    mode_d = mode_q;
    if (accept) begin
      col_d = row_end ? '0 : col_q + CW'(1);
      if (row_end) row_d = frame_end ? '0 : row_q + RW'(1);
      acc_d = h;
      if (first_px) mode_d = mode;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = mode_eff ? WIDTH'(v >>> SH) : WIDTH'(v);
      out_last_d  = frame_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      acc_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Every entry is written at ky == 0 before any read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept && h_done && (ky != LK'(K-1))) pbuf_q[wc] <= v;
  end

endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream: a K=2 4x4 instance and a K=4 8x8 instance.
module tb_pool_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mode, out_ready;
  logic [8:0] in_data;
  logic       v2, v4, rdy2, rdy4, ov2, ov4, ol2, ol4;
  logic [8:0] od2, od4;

  pool_stream #(.WIDTH(9), .IMG_W(4), .IMG_H(4), .K(2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(v2), .in_ready(rdy2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_last(ol2));

  pool_stream #(.WIDTH(9), .IMG_W(8), .IMG_H(8), .K(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(v4), .in_ready(rdy4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_last(ol4));

  typedef struct {
    logic signed [31:0] d;
    logic               l;
    int                 c;
  } out_t;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  out_t q2[$], q4[$];
  int   a2[$], a4[$];
  out_t e2, e4;

  always @(posedge clk) cyc <= cyc + 1;

  // Log accepted pixels and output handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (v2 && rdy2) a2.push_back(cyc);
    if (v4 && rdy4) a4.push_back(cyc);
    if (ov2 && out_ready) begin
      e2.d = $signed(od2); e2.l = ol2; e2.c = cyc; q2.push_back(e2);
    end
    if (ov4 && out_ready) begin
      e4.d = $signed(od4); e4.l = ol4; e4.c = cyc; q4.push_back(e4);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input bit k4, input logic [8:0] px);
    int t;
    in_data = px;
    if (k4) v4 = 1'b1; else v2 = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(k4 ? rdy4 : rdy2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", k4 ? rdy4 : rdy2, 1);
    @(posedge clk); #1;
    v2 = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input bit k4, input int x0, input int x1,
                        input int x2, input int x3, input bit timing);
    out_t q[$];
    int   a[$];
    int   e[4];
    int   idx[4];
    e = '{x0, x1, x2, x3};
    if (k4) begin q = q4; a = a4; idx = '{27, 31, 59, 63}; end
    else    begin q = q2; a = a2; idx = '{5, 7, 13, 15}; end
    chk({tag, "_count"}, q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        chk($sformatf("%s_data%0d", tag, i), q[i].d, e[i]);
        chk($sformatf("%s_last%0d", tag, i), q[i].l, (i == 3) ? 1 : 0);
        if (timing && a.size() > idx[i])
          chk($sformatf("%s_lat%0d", tag, i), q[i].c, a[idx[i]] + 1);
      end
    end
    q2.delete(); q4.delete(); a2.delete(); a4.delete();
  endtask

  int nv[16] = '{-1, -2, -256, -256, -3, -4, -256, -256, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1; v2 = 1'b0; v4 = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov2, 0);
    chk("rst_out_data", od2, 0);
    chk("rst_out_last", ol2, 0);
    chk("rst_in_ready", rdy2, 0);
    chk("rst_out_valid_k4", ov4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", rdy2, 1);
    @(posedge clk); #1;

    mode = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 9'(i));
    settle();
    check4("max2", 0, 5, 7, 13, 15, 1);

    mode = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 9'(i));
    settle();
    check4("avg2", 0, 2, 4, 10, 12, 1);

    mode = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 9'(nv[i]));
    settle();
    check4("neg_max", 0, -1, -256, 0, 0, 0);

    mode = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 9'(nv[i]));
    settle();
    check4("neg_avg", 0, -3, -256, 0, 0, 0);

    // Stall the output right after the first result appears.
    mode = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(0, 9'(i));
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(posedge clk); #1;
          if (ov2) break;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready", rdy2, 0);
        chk("bp_data", od2, 5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_hold_valid", ov2, 1);
        chk("bp_hold_data", od2, 5);
        chk("bp_hold_in_ready", rdy2, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    settle();
    check4("bp", 0, 5, 7, 13, 15, 0);

    mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) mode = 1'b0;
      send(0, 9'(i));
    end
    settle();
    check4("latch_avg", 0, 2, 4, 10, 12, 0);

    mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) mode = 1'b1;
      send(0, 9'(i));
    end
    settle();
    check4("latch_max", 0, 5, 7, 13, 15, 0);

    // Partial frame leaves a pending result that reset must drop.
    mode = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 9'(i));
    @(negedge clk);
    chk("mid_pending", ov2, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", rdy2, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_dropped", ov2, 0);
    chk("mid_no_drain", q2.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    a2.delete(); q2.delete();
    for (int i = 0; i < 16; i++) send(0, 9'(i));
    settle();
    check4("after_rst", 0, 5, 7, 13, 15, 1);

    mode = 1'b0;
    for (int i = 0; i < 64; i++) send(1, 9'(i));
    settle();
    check4("max4", 1, 27, 31, 59, 63, 1);

    mode = 1'b1;
    for (int i = 0; i < 64; i++) send(1, 9'(i));
    settle();
    check4("avg4", 1, 13, 17, 45, 49, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming 2-D pooling engine for raster-ordered feature maps. It generalises fixed 2x2 max pooling to a parametrised K x K window with stride K, selectable max or average mode, and valid/ready handshakes on both sides. It sits between a convolution/activation stage and the next layer's input buffer. It consumes one pixel per accepted beat and emits one pooled result per completed window, using a single row of partial-result buffers in place of a full-frame buffer.

## Interface
- WIDTH, 9: signed pixel width, input and output.
- IMG_W, 28: input feature-map width in pixels; must be a multiple of K.
- IMG_H, 28: input feature-map height in pixels; must be a multiple of K.
- K, 2: window size and stride; legal values are 2 and 4.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = max pooling, 1 = average pooling; sampled only on a frame's first accepted pixel.
- in_valid  in  1  in_data carries a pixel.
- in_ready  out  1  block accepts a pixel this cycle.
- in_data  in  WIDTH  signed pixel, raster order (row-major, top-left first).
- out_valid  out  1  out_data carries a pooled value.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  signed pooled value.
- out_last  out  1  marks the final pooled value of a frame; qualified by out_valid.

## Operation
- Accept occurs when in_valid && in_ready. Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accept. col wraps to 0 and increments row; row wraps to 0 at frame end.
- Window coordinates: kx = col mod K, ky = row mod K, window column wc = col / K.
- Horizontal accumulator acc:
  - acc is loaded with the pixel when kx == 0.
  - Otherwise, in max mode, acc becomes max(acc, pixel), compared as signed.
  - Otherwise, in average mode, acc becomes acc + pixel, using width WIDTH + 2*log2(K) and sign extension.
- Row buffer pbuf holds IMG_W/K entries, each WIDTH + 2*log2(K) bits. When kx == K-1, the horizontally complete value h (acc merged with the current pixel) is combined with pbuf[wc]:
  - ky == 0: pbuf[wc] is set to h.
  - 0 < ky < K-1: pbuf[wc] is set to max(pbuf[wc], h) or to pbuf[wc] + h.
  - ky == K-1: the window result is combined and registered to the output; pbuf[wc] is not updated.
- Average result: the full sum is arithmetically shifted right by 2*log2(K), which floors toward minus infinity, then truncated to WIDTH. The result always fits in WIDTH.
- Mode latch: mode is captured into mode_q when the pixel at row 0, col 0 is accepted. mode_q governs that pixel and the whole frame. Changes to mode mid-frame have no effect.
- out_last = 1 for the window containing pixel (IMG_H-1, IMG_W-1).
- Output register is a single entry:
  - in_ready = !rst && (!out_valid || out_ready).
  - out_valid is set when a window completes and clears when out_valid && out_ready with no new completion in the same cycle.
  - A completion can coincide with a draining handshake. In that case the register reloads and out_valid stays 1.
- No input is lost, because in_ready deasserts whenever the output is full and not draining.
- Reset: col, row, acc, mode_q = 0; out_valid = 0, out_data = 0, out_last = 0. pbuf contents are don't-care, since each entry is always written at ky == 0 before it is read.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0). A pending output is dropped.

## Timing
- Latency: out_valid rises on the cycle after the window's final pixel (kx == K-1, ky == K-1) is accepted.
- Throughput: one pixel per cycle when out_ready is held high. There is at most one output per K*K inputs, so continuous flow never stalls the input.
- in_ready is combinational from out_valid, out_ready and rst. It has no combinational path from in_valid.
- out_data and out_last are stable while out_valid && !out_ready.
- Row buffer read and write occur in the same accept cycle (read-before-write on pbuf[wc]). It may be a register array or distributed RAM with an asynchronous read.

## Test plan
- Max, K=2, IMG_W=IMG_H=4, mode=0, in_data = 0..15 raster, out_ready=1 -> outputs 5, 7, 13, 15. out_last only on 15. Each output appears 1 cycle after pixels 5, 7, 13, 15 respectively.
- Average, same frame with mode=1 -> outputs 2, 4, 10, 12 (sums 10, 18, 42, 50 shifted right by 2); out_last on 12.
- Negative and floor, K=2, window pixels -1, -2, -3, -4 -> max gives -1; average gives -3 (sum -10 shifted right by 2 floors to -3, not -2). Also -256 x 4 with WIDTH=9 -> average -256, with no overflow.
- Backpressure: hold out_ready=0 after the first output -> in_ready drops as soon as out_valid=1, and out_data holds 5. Release after 10 cycles -> the stream resumes with no loss or duplication, and the sequence is unchanged.
- Mode latch and reset: toggle mode mid-frame -> results follow the mode present at pixel (0,0). Assert rst after 6 pixels, then send a full 0..15 frame -> outputs 5, 7, 13, 15 with no stale output.
- K=4, IMG_W=IMG_H=8, in_data = 0..63 -> max gives 27, 31, 59, 63. Average gives 13, 17, 45, 49 (sums 216, 280, 728, 792 shifted right by 4).
